// File: rtl/siganfu_gun_pkg.sv
// Shared definitions for the siganfu gun controller: state and firing-mode
// encodings plus counter-width helpers.
package siganfu_gun_pkg;

    // Controller states; encoding 3'd7 is unused and recovers to ST_IDLE.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SINGLE   = 3'd1,
        ST_AUTO     = 3'd2,
        ST_BURST    = 3'd3,
        ST_RELOAD   = 3'd4,
        ST_COOLDOWN = 3'd5,
        ST_EMPTY    = 3'd6
    } state_e;

    // firing_mode encodings; 2'b11 falls back to single shot.
    localparam logic [1:0] MODE_SINGLE = 2'b00;
    localparam logic [1:0] MODE_AUTO   = 2'b01;
    localparam logic [1:0] MODE_BURST  = 2'b10;

    // Bits needed to hold values 0..max_val (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        if (max_val == 0) begin
            return 1;
        end
        return $clog2(max_val + 1);
    endfunction

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/siganfu_down_timer.sv
// Saturating down-counter shared by the RELOAD and COOLDOWN phases.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   load       : load 'value' into the counter this edge
//   value      : cycles remaining minus one at load time
//   done       : registered, high once the counter has reached zero
module siganfu_down_timer #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         done
);

    logic [W-1:0] r_cnt;
    logic         r_done;

    // done tracks (r_cnt == 0) but is produced by the register itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_done <= 1'b1;
        end else if (load) begin
            r_cnt  <= value;
            r_done <= (value == '0);
        end else begin
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - W'(1);
            end
            r_done <= (r_cnt <= W'(1));
        end
    end

    assign done = r_done;

endmodule

// File: rtl/siganfu_gun_controller.sv
// Machine-gun fire controller: gates every shot on the full safety condition,
// supports single / automatic / burst modes, tracks magazine and spare stock,
// and sequences timed RELOAD and COOLDOWN phases.
// Ports:
//   sysclk, reboot_n  : clock, asynchronous active-low reset
//   target_locked, is_enemy, fire_command, overheat_sensor : safety inputs
//   firing_mode       : 00 single, 01 auto, 10 burst, 11 single
//   current_state     : registered state encoding (0..6)
//   fire_trigger      : one-cycle pulse per round fired
//   criticality_alert : high while in COOLDOWN or EMPTY
//   rounds_left, mags_left : ammunition counters
module siganfu_gun_controller
    import siganfu_gun_pkg::*;
#(
    parameter int unsigned MAG_SIZE        = 25,
    parameter int unsigned MAG_COUNT       = 2,
    parameter int unsigned BURST_LEN       = 3,
    parameter int unsigned RELOAD_CYCLES   = 5,
    parameter int unsigned COOLDOWN_CYCLES = 10
) (
    input  logic                               sysclk,
    input  logic                               reboot_n,
    input  logic                               target_locked,
    input  logic                               is_enemy,
    input  logic                               fire_command,
    input  logic [1:0]                         firing_mode,
    input  logic                               overheat_sensor,
    output logic [2:0]                         current_state,
    output logic                               fire_trigger,
    output logic                               criticality_alert,
    output logic [cnt_width(MAG_SIZE)-1:0]     rounds_left,
    output logic [cnt_width(MAG_COUNT)-1:0]    mags_left
);

    localparam int unsigned RW = cnt_width(MAG_SIZE);
    localparam int unsigned MW = cnt_width(MAG_COUNT);
    localparam int unsigned BW = cnt_width(BURST_LEN);
    localparam int unsigned TW = cnt_width(max2(RELOAD_CYCLES, COOLDOWN_CYCLES));

    localparam logic [RW-1:0] FULL_MAG    = RW'(MAG_SIZE);
    localparam logic [MW-1:0] MAGS_INIT   = MW'(MAG_COUNT);
    localparam logic [BW-1:0] BURST_FULL  = BW'(BURST_LEN);
    localparam logic [TW-1:0] RELOAD_LOAD = TW'(RELOAD_CYCLES - 1);
    localparam logic [TW-1:0] COOL_LOAD   = TW'(COOLDOWN_CYCLES - 1);

    state_e          r_state;
    logic            r_fire;
    logic            r_alert;
    logic [RW-1:0]   r_rounds;
    logic [MW-1:0]   r_mags;
    logic [BW-1:0]   r_burst_cnt;

    state_e          w_nxt;
    state_e          w_dry_state;
    logic            w_fire;
    logic            w_refill;
    logic            w_fire_ok;
    logic            w_mag_empty;
    logic [BW-1:0]   w_burst_cnt;
    logic            w_tmr_load;
    logic [TW-1:0]   w_tmr_value;
    logic            w_tmr_done;

    assign w_fire_ok   = target_locked & is_enemy & fire_command & ~overheat_sensor;
    assign w_mag_empty = (r_rounds == '0);
    // Where an empty magazine leads: reload if stock remains, else terminal.
    assign w_dry_state = (r_mags != '0) ? ST_RELOAD : ST_EMPTY;

    // Next-state, shot and refill decisions.
    always_comb begin
        w_nxt       = r_state;
        w_fire      = 1'b0;
        w_refill    = 1'b0;
        w_burst_cnt = r_burst_cnt;
        case (r_state)
            ST_IDLE: begin
                if (overheat_sensor) begin
                    w_nxt = ST_COOLDOWN;
                end else if (w_fire_ok) begin
                    if (w_mag_empty) begin
                        w_nxt = w_dry_state;
                    end else begin
                        w_fire      = 1'b1;
                        w_burst_cnt = BW'(1);
                        case (firing_mode)
                            MODE_AUTO:   w_nxt = ST_AUTO;
                            MODE_BURST:  w_nxt = ST_BURST;
                            MODE_SINGLE: w_nxt = ST_SINGLE;
                            default:     w_nxt = ST_SINGLE;
                        endcase
                    end
                end
            end
            ST_SINGLE, ST_AUTO, ST_BURST: begin
                if (overheat_sensor) begin
                    w_nxt = ST_COOLDOWN;
                end else if (w_mag_empty) begin
                    w_nxt = w_dry_state;
                end else if (r_state == ST_SINGLE) begin
                    if (!fire_command) begin
                        w_nxt = ST_IDLE;
                    end
                end else if (r_state == ST_AUTO) begin
                    if (w_fire_ok) begin
                        w_fire = 1'b1;
                    end else begin
                        w_nxt = ST_IDLE;
                    end
                end else begin
                    // Burst: keep firing until BURST_LEN shots, abort on any drop.
                    if (r_burst_cnt < BURST_FULL) begin
                        if (w_fire_ok) begin
                            w_fire      = 1'b1;
                            w_burst_cnt = r_burst_cnt + BW'(1);
                        end else begin
                            w_nxt = ST_IDLE;
                        end
                    end else if (!fire_command) begin
                        w_nxt = ST_IDLE;
                    end
                end
            end
            ST_RELOAD: begin
                if (w_tmr_done) begin
                    w_nxt    = ST_IDLE;
                    w_refill = 1'b1;
                end
            end
            ST_COOLDOWN: begin
                if (w_tmr_done && !overheat_sensor) begin
                    w_nxt = w_mag_empty ? w_dry_state : ST_IDLE;
                end
            end
            ST_EMPTY: begin
                w_nxt = ST_EMPTY;
            end
            default: begin
                w_nxt = ST_IDLE;
            end
        endcase
    end

    // Timer is loaded only on entry into a timed phase.
    always_comb begin
        w_tmr_load  = 1'b0;
        w_tmr_value = '0;
        if ((w_nxt == ST_RELOAD) && (r_state != ST_RELOAD)) begin
            w_tmr_load  = 1'b1;
            w_tmr_value = RELOAD_LOAD;
        end else if ((w_nxt == ST_COOLDOWN) && (r_state != ST_COOLDOWN)) begin
            w_tmr_load  = 1'b1;
            w_tmr_value = COOL_LOAD;
        end
    end

    siganfu_down_timer #(
        .W (TW)
    ) u_timer (
        .clk   (sysclk),
        .rst_n (reboot_n),
        .load  (w_tmr_load),
        .value (w_tmr_value),
        .done  (w_tmr_done)
    );

    // State and output registers.
    always_ff @(posedge sysclk or negedge reboot_n) begin
        if (!reboot_n) begin
            r_state     <= ST_IDLE;
            r_fire      <= 1'b0;
            r_alert     <= 1'b0;
            r_rounds    <= FULL_MAG;
            r_mags      <= MAGS_INIT;
            r_burst_cnt <= '0;
        end else begin
            r_state     <= w_nxt;
            r_fire      <= w_fire;
            r_alert     <= (w_nxt == ST_COOLDOWN) || (w_nxt == ST_EMPTY);
            r_burst_cnt <= w_burst_cnt;
            if (w_fire) begin
                r_rounds <= r_rounds - RW'(1);
            end else if (w_refill) begin
                r_rounds <= FULL_MAG;
            end
            if (w_refill) begin
                r_mags <= r_mags - MW'(1);
            end
        end
    end

    assign current_state     = r_state;
    assign fire_trigger      = r_fire;
    assign criticality_alert = r_alert;
    assign rounds_left       = r_rounds;
    assign mags_left         = r_mags;

endmodule

// File: tb/tb_siganfu_gun_controller.sv
// Self-checking bench for siganfu_gun_controller: directed scenarios with
// literal expectations plus randomized stimulus, all compared every cycle
// against a behavioural model of the firing rules.
module tb_siganfu_gun_controller;

    localparam int unsigned MAG  = 25;
    localparam int unsigned NMAG = 1;
    localparam int unsigned BL   = 3;
    localparam int unsigned RLD  = 5;
    localparam int unsigned CD   = 10;
    localparam int unsigned RW   = $clog2(MAG + 1);
    localparam int unsigned MW   = $clog2(NMAG + 1);

    logic          sysclk          = 1'b0;
    logic          reboot_n        = 1'b0;
    logic          target_locked   = 1'b0;
    logic          is_enemy        = 1'b0;
    logic          fire_command    = 1'b0;
    logic          overheat_sensor = 1'b0;
    logic [1:0]    firing_mode     = 2'b00;
    logic [2:0]    current_state;
    logic          fire_trigger;
    logic          criticality_alert;
    logic [RW-1:0] rounds_left;
    logic [MW-1:0] mags_left;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Behavioural model: state number, ammo, shots in current burst,
    // cycles already spent in the current timed phase.
    int m_st, m_rounds, m_mags, m_shots, m_elapsed, m_fire, m_alert;

    int pulses, rl_cyc, cd_cyc, guard, refill_seen;
    logic [2:0] prev;

    siganfu_gun_controller #(
        .MAG_SIZE        (MAG),
        .MAG_COUNT       (NMAG),
        .BURST_LEN       (BL),
        .RELOAD_CYCLES   (RLD),
        .COOLDOWN_CYCLES (CD)
    ) dut (
        .sysclk            (sysclk),
        .reboot_n          (reboot_n),
        .target_locked     (target_locked),
        .is_enemy          (is_enemy),
        .fire_command      (fire_command),
        .firing_mode       (firing_mode),
        .overheat_sensor   (overheat_sensor),
        .current_state     (current_state),
        .fire_trigger      (fire_trigger),
        .criticality_alert (criticality_alert),
        .rounds_left       (rounds_left),
        .mags_left         (mags_left)
    );

    always #5 sysclk = ~sysclk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_st      = 0;
        m_rounds  = MAG;
        m_mags    = NMAG;
        m_shots   = 0;
        m_elapsed = 0;
        m_fire    = 0;
        m_alert   = 0;
    endtask

    function automatic int dry_target(input int mags);
        return (mags > 0) ? 4 : 6;
    endfunction

    // One clock edge of the firing rules, using the inputs held at that edge.
    task automatic model_step();
        bit ok;
        int nxt;
        ok     = target_locked && is_enemy && fire_command && !overheat_sensor;
        nxt    = m_st;
        m_fire = 0;
        case (m_st)
            0: begin
                if (overheat_sensor) nxt = 5;
                else if (ok) begin
                    if (m_rounds == 0) nxt = dry_target(m_mags);
                    else begin
                        m_fire  = 1;
                        m_shots = 1;
                        nxt = (firing_mode == 2'b01) ? 2 : (firing_mode == 2'b10) ? 3 : 1;
                    end
                end
            end
            1, 2, 3: begin
                if (overheat_sensor) nxt = 5;
                else if (m_rounds == 0) nxt = dry_target(m_mags);
                else if (m_st == 1) begin
                    if (!fire_command) nxt = 0;
                end else if (m_st == 2) begin
                    if (ok) m_fire = 1;
                    else nxt = 0;
                end else begin
                    if (m_shots < BL) begin
                        if (ok) begin
                            m_fire = 1;
                            m_shots++;
                        end else nxt = 0;
                    end else if (!fire_command) nxt = 0;
                end
            end
            4: begin
                m_elapsed++;
                if (m_elapsed == RLD) begin
                    m_rounds = MAG;
                    m_mags--;
                    nxt = 0;
                end
            end
            5: begin
                m_elapsed++;
                if (m_elapsed >= CD && !overheat_sensor)
                    nxt = (m_rounds == 0) ? dry_target(m_mags) : 0;
            end
            default: nxt = m_st;
        endcase
        if (m_fire != 0) m_rounds--;
        if (nxt != m_st) m_elapsed = 0;
        m_alert = (nxt == 5 || nxt == 6) ? 1 : 0;
        m_st    = nxt;
    endtask

    // Model advances on every edge (or immediately on reset assertion).
    initial begin
        model_reset();
        forever begin
            @(posedge sysclk or negedge reboot_n);
            if (!reboot_n) model_reset();
            else model_step();
        end
    end

    // Per-cycle comparison of every output against the model.
    initial begin
        forever begin
            @(posedge sysclk);
            #1;
            if (chk_en) begin
                chk("cmp_state",  int'(current_state),     m_st);
                chk("cmp_fire",   int'(fire_trigger),      m_fire);
                chk("cmp_alert",  int'(criticality_alert), m_alert);
                chk("cmp_rounds", int'(rounds_left),       m_rounds);
                chk("cmp_mags",   int'(mags_left),         m_mags);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog at %0t: got timeout expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic cyc();
        @(negedge sysclk);
    endtask

    task automatic set_in(input bit tl, input bit en, input bit fc, input bit oh, input logic [1:0] md);
        target_locked   = tl;
        is_enemy        = en;
        fire_command    = fc;
        overheat_sensor = oh;
        firing_mode     = md;
    endtask

    task automatic do_reset();
        @(negedge sysclk);
        reboot_n = 1'b0;
        set_in(0, 0, 0, 0, 2'b00);
        @(negedge sysclk);
        reboot_n = 1'b1;
    endtask

    task automatic count_cyc();
        cyc();
        if (fire_trigger) pulses++;
    endtask

    initial begin
        chk_en = 1'b1;
        do_reset();
        chk("reset_state",  int'(current_state),     0);
        chk("reset_fire",   int'(fire_trigger),      0);
        chk("reset_alert",  int'(criticality_alert), 0);
        chk("reset_rounds", int'(rounds_left),       25);
        chk("reset_mags",   int'(mags_left),         1);

        // Safety gate: any missing condition blocks firing.
        for (int md = 0; md < 2; md++) begin
            for (int d = 0; d < 3; d++) begin
                set_in(d != 0, d != 1, d != 2, 0, 2'(md));
                pulses = 0;
                repeat (3) count_cyc();
                chk("safety_pulses", pulses, 0);
                chk("safety_state",  int'(current_state), 0);
                chk("safety_rounds", int'(rounds_left),   25);
            end
        end

        // Single shot.
        do_reset();
        set_in(1, 1, 1, 0, 2'b00);
        cyc();
        chk("first_shot_latency", int'(fire_trigger), 1);
        pulses = 1;
        repeat (4) count_cyc();
        chk("single_pulses", pulses, 1);
        chk("single_state",  int'(current_state), 1);
        chk("single_rounds", int'(rounds_left),   24);
        set_in(1, 1, 0, 0, 2'b00);
        cyc();
        chk("single_release", int'(current_state), 0);

        // Burst, full then aborted.
        do_reset();
        set_in(1, 1, 1, 0, 2'b10);
        pulses = 0;
        repeat (8) count_cyc();
        chk("burst_pulses", pulses, 3);
        chk("burst_rounds", int'(rounds_left), 22);
        chk("burst_hold",   int'(current_state), 3);
        set_in(1, 1, 0, 0, 2'b10);
        cyc();
        chk("burst_release", int'(current_state), 0);
        set_in(1, 1, 1, 0, 2'b10);
        pulses = 0;
        repeat (2) count_cyc();
        set_in(1, 0, 1, 0, 2'b10);
        repeat (3) count_cyc();
        chk("burst_abort_pulses", pulses, 2);
        chk("burst_abort_state",  int'(current_state), 0);
        chk("burst_abort_rounds", int'(rounds_left), 20);

        // Auto until both magazines are spent.
        do_reset();
        set_in(1, 1, 1, 0, 2'b01);
        pulses = 0; rl_cyc = 0; refill_seen = 0;
        for (int i = 0; i < 60; i++) begin
            prev = current_state;
            count_cyc();
            if (current_state == 3'd4) rl_cyc++;
            if (prev == 3'd4 && current_state == 3'd0) begin
                refill_seen++;
                chk("refill_rounds", int'(rounds_left), 25);
                chk("refill_mags",   int'(mags_left),   0);
            end
        end
        chk("auto_pulses",    pulses, 50);
        chk("auto_reload",    rl_cyc, 5);
        chk("auto_refill",    refill_seen, 1);
        chk("empty_state",    int'(current_state), 6);
        chk("empty_alert",    int'(criticality_alert), 1);
        for (int i = 0; i < 20; i++) begin
            set_in($urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0,
                   $urandom_range(0, 1) != 0, 2'($urandom_range(0, 3)));
            count_cyc();
        end
        chk("empty_ignored_pulses", pulses, 50);
        chk("empty_ignored_state",  int'(current_state), 6);

        // Overheat held for 15 cycles during auto fire.
        do_reset();
        set_in(1, 1, 1, 0, 2'b01);
        pulses = 0; guard = 0;
        while (pulses < 7 && guard < 20) begin
            count_cyc();
            guard++;
        end
        chk("oh_pre_pulses", pulses, 7);
        set_in(1, 1, 1, 1, 2'b01);
        cyc();
        chk("oh_fire",  int'(fire_trigger), 0);
        chk("oh_state", int'(current_state), 5);
        chk("oh_alert", int'(criticality_alert), 1);
        cd_cyc = 1;
        repeat (14) begin
            cyc();
            if (current_state == 3'd5 && criticality_alert) cd_cyc++;
        end
        set_in(1, 1, 0, 0, 2'b01);
        cyc();
        chk("oh_cycles",      cd_cyc, 15);
        chk("oh_exit_state",  int'(current_state), 0);
        chk("oh_exit_rounds", int'(rounds_left), 18);
        chk("model_rounds_pin", m_rounds, 18);

        // Short overheat still costs the minimum cooldown.
        set_in(0, 0, 0, 1, 2'b00);
        cd_cyc = 0;
        repeat (2) begin
            cyc();
            if (current_state == 3'd5) cd_cyc++;
        end
        set_in(0, 0, 0, 0, 2'b00);
        repeat (12) begin
            cyc();
            if (current_state == 3'd5) cd_cyc++;
        end
        chk("cd_min_cycles", cd_cyc, 10);
        chk("cd_min_exit",   int'(current_state), 0);

        // Asynchronous reset in the middle of RELOAD.
        do_reset();
        set_in(1, 1, 1, 0, 2'b01);
        repeat (27) cyc();
        chk("mid_reload_state", int'(current_state), 4);
        @(posedge sysclk);
        #3;
        reboot_n = 1'b0;
        #1;
        chk("async_state",  int'(current_state), 0);
        chk("async_fire",   int'(fire_trigger), 0);
        chk("async_alert",  int'(criticality_alert), 0);
        chk("async_rounds", int'(rounds_left), 25);
        chk("async_mags",   int'(mags_left), 1);
        @(negedge sysclk);
        reboot_n = 1'b1;
        set_in(1, 1, 1, 0, 2'b00);
        cyc();
        chk("resume_fire",   int'(fire_trigger), 1);
        chk("resume_rounds", int'(rounds_left), 24);
        chk("resume_mags",   int'(mags_left), 1);

        // Randomized traffic with occasional resets; model checks every cycle.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                reboot_n = 1'b0;
                cyc();
                reboot_n = 1'b1;
            end
            set_in($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                   $urandom_range(0, 19) == 0, 2'($urandom_range(0, 3)));
            cyc();
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
